presettable_down_counter: RTL and testbench

- Synchronous, presettable, cascadable binary down counter. It is the count-down counterpart of the team's 4-bit up counter and keeps the same control set (sync load, CTP/CTT enables).
- Adds a borrow chain, an optional auto-reload divider mode and a sticky underflow flag.
- Used as a programmable clock divider or timeout timer. Several instances chain through BO into CTT.

---
 rtl/presettable_down_counter_pkg.sv | 13 +
 rtl/presettable_down_counter_down_stage4.sv | 40 ++++
 rtl/presettable_down_counter.sv | 72 +++++++
 tb/tb_presettable_down_counter.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/presettable_down_counter_pkg.sv
// Shared constants and terminal-count helper for the presettable down counter.
package presettable_down_counter_pkg;

  localparam int unsigned WIDTH_DEFAULT = 4;
  localparam int unsigned STAGE_W       = 4;
  localparam int unsigned MAX_W         = 64;

  // Callers zero-extend their value to MAX_W so one helper serves every width.
  function automatic logic zero(input logic [MAX_W-1:0] v);
    return (v == '0);
  endfunction

endpackage

// File: rtl/presettable_down_counter_down_stage4.sv
// 4-bit down-counting slice with sync load and a CTT->BO borrow ripple.
module down_stage4
  import presettable_down_counter_pkg::*;
#(
  parameter logic [STAGE_W-1:0] RST_VAL = '0
) (
  input  logic               cp_i,
  input  logic               cr_i,
  input  logic               load_i,
  input  logic [STAGE_W-1:0] d_i,
  input  logic               ctp_i,
  input  logic               ctt_i,
  output logic [STAGE_W-1:0] q_o,
  output logic               bo_o
);

  logic [STAGE_W-1:0] q_q;
  logic [STAGE_W-1:0] q_d;

  always_comb begin
    q_d = q_q;
    if (load_i) begin
      q_d = d_i;
    end else if (ctp_i && ctt_i) begin
      q_d = q_q - STAGE_W'(1);
    end
  end

  always_ff @(posedge cp_i or posedge cr_i) begin
    if (cr_i) begin
      q_q <= RST_VAL;
    end else begin
      q_q <= q_d;
    end
  end

  assign q_o  = q_q;
  assign bo_o = ctt_i & zero(MAX_W'(q_q));

endmodule

// File: rtl/presettable_down_counter.sv
// Cascadable presettable down counter: chained 4-bit slices, optional auto-reload,
// registered terminal-count pulse and sticky underflow flag.
module presettable_down_counter
  import presettable_down_counter_pkg::*;
#(
  parameter int unsigned      WIDTH   = WIDTH_DEFAULT,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             CP,
  input  logic             CR,
  input  logic             LDbar,
  input  logic             CTP,
  input  logic             CTT,
  input  logic             RELOAD,
  input  logic             CLRUF,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic             BO,
  output logic             TCP,
  output logic             UF
);

  localparam int unsigned NSTAGE = WIDTH / STAGE_W;

  logic [NSTAGE:0] ctt_chain;
  logic            underflow_c;
  logic            slice_load_c;
  logic            tcp_q, tcp_d;
  logic            uf_q, uf_d;

  // The end of the borrow chain is high only when CTT is set and every slice is zero.
  assign ctt_chain[0] = CTT;
  assign underflow_c  = LDbar & CTP & ctt_chain[NSTAGE];
  // Without reload the slices wrap to all ones by decrementing through zero.
  assign slice_load_c = ~LDbar | (underflow_c & RELOAD);

  for (genvar i = 0; i < NSTAGE; i++) begin : g_stage
    down_stage4 #(
      .RST_VAL(RST_VAL[i*STAGE_W +: STAGE_W])
    ) u_stage (
      .cp_i  (CP),
      .cr_i  (CR),
      .load_i(slice_load_c),
      .d_i   (D[i*STAGE_W +: STAGE_W]),
      .ctp_i (CTP),
      .ctt_i (ctt_chain[i]),
      .q_o   (Q[i*STAGE_W +: STAGE_W]),
      .bo_o  (ctt_chain[i+1])
    );
  end

  // Underflow sets UF even when CLRUF arrives on the same edge.
  always_comb begin
    tcp_d = underflow_c;
    uf_d  = underflow_c | (uf_q & ~CLRUF);
  end

  always_ff @(posedge CP or posedge CR) begin
    if (CR) begin
      tcp_q <= 1'b0;
      uf_q  <= 1'b0;
    end else begin
      tcp_q <= tcp_d;
      uf_q  <= uf_d;
    end
  end

  assign BO  = ctt_chain[NSTAGE];
  assign TCP = tcp_q;
  assign UF  = uf_q;

endmodule

// File: tb/tb_presettable_down_counter.sv
// Directed vector bench for presettable_down_counter at WIDTH=4 and WIDTH=8.
module tb_presettable_down_counter;

  typedef struct {
    logic       ldbar;
    logic       ctp;
    logic       ctt;
    logic       reload;
    logic       clruf;
    logic [3:0] d;
    logic [3:0] q;
    logic       bo;
    logic       tcp;
    logic       uf;
  } vec_t;

  logic       cp = 1'b0;
  logic       cr = 1'b1;
  logic       ldbar = 1'b1;
  logic       ctp = 1'b0;
  logic       ctt = 1'b0;
  logic       reload = 1'b0;
  logic       clruf = 1'b0;
  logic [3:0] d4 = '0;
  logic [7:0] d8 = '0;
  logic [3:0] q4;
  logic [7:0] q8;
  logic       bo4, tcp4, uf4;
  logic       bo8, tcp8, uf8;

  int n_checks = 0;
  int n_fail   = 0;
  vec_t vecs[$];

  always #5 cp = ~cp;

  presettable_down_counter #(.WIDTH(4)) dut4 (
    .CP(cp), .CR(cr), .LDbar(ldbar), .CTP(ctp), .CTT(ctt), .RELOAD(reload),
    .CLRUF(clruf), .D(d4), .Q(q4), .BO(bo4), .TCP(tcp4), .UF(uf4)
  );

  presettable_down_counter #(.WIDTH(8)) dut8 (
    .CP(cp), .CR(cr), .LDbar(ldbar), .CTP(ctp), .CTT(ctt), .RELOAD(reload),
    .CLRUF(clruf), .D(d8), .Q(q8), .BO(bo8), .TCP(tcp8), .UF(uf8)
  );

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic ld, input logic p, input logic t, input logic rl,
                              input logic cl, input logic [3:0] d, input logic [3:0] q,
                              input logic bo, input logic tcp, input logic uf);
    vec_t v;
    v.ldbar = ld; v.ctp = p; v.ctt = t; v.reload = rl; v.clruf = cl;
    v.d = d; v.q = q; v.bo = bo; v.tcp = tcp; v.uf = uf;
    return v;
  endfunction

  task automatic drive(input logic ld, input logic p, input logic t, input logic rl,
                       input logic cl, input logic [3:0] dv4, input logic [7:0] dv8);
    @(negedge cp);
    ldbar = ld; ctp = p; ctt = t; reload = rl; clruf = cl; d4 = dv4; d8 = dv8;
    @(posedge cp);
    #1;
  endtask

  task automatic step8(input string name, input logic ld, input logic p, input logic t,
                       input logic rl, input logic [7:0] dv, input logic [7:0] eq,
                       input logic ebo, input logic etcp, input logic euf);
    drive(ld, p, t, rl, 1'b0, 4'h0, dv);
    check({name, " q8"}, q8, eq);
    check({name, " bo8"}, 8'(bo8), 8'(ebo));
    check({name, " tcp8"}, 8'(tcp8), 8'(etcp));
    check({name, " uf8"}, 8'(uf8), 8'(euf));
  endtask

  initial begin
    // ld ctp ctt rel clr d -> q bo tcp uf
    vecs.push_back(mk(0, 1, 1, 0, 0, 4'hC, 4'hC, 0, 0, 0));
    vecs.push_back(mk(1, 1, 1, 0, 0, 4'hC, 4'hB, 0, 0, 0));
    vecs.push_back(mk(1, 1, 1, 0, 0, 4'hC, 4'hA, 0, 0, 0));
    vecs.push_back(mk(1, 1, 1, 0, 0, 4'hC, 4'h9, 0, 0, 0));
    vecs.push_back(mk(0, 1, 1, 0, 0, 4'h2, 4'h2, 0, 0, 0));
    vecs.push_back(mk(1, 1, 1, 0, 0, 4'h2, 4'h1, 0, 0, 0));
    vecs.push_back(mk(1, 1, 1, 0, 0, 4'h2, 4'h0, 1, 0, 0));
    vecs.push_back(mk(1, 1, 1, 0, 0, 4'h2, 4'hF, 0, 1, 1));
    vecs.push_back(mk(1, 1, 1, 0, 0, 4'h2, 4'hE, 0, 0, 1));
    vecs.push_back(mk(1, 0, 0, 0, 1, 4'h2, 4'hE, 0, 0, 0));
    vecs.push_back(mk(0, 1, 1, 1, 0, 4'h3, 4'h3, 0, 0, 0));
    vecs.push_back(mk(1, 1, 1, 1, 0, 4'h3, 4'h2, 0, 0, 0));
    vecs.push_back(mk(1, 1, 1, 1, 0, 4'h3, 4'h1, 0, 0, 0));
    vecs.push_back(mk(1, 1, 1, 1, 0, 4'h3, 4'h0, 1, 0, 0));
    vecs.push_back(mk(1, 1, 1, 1, 0, 4'h3, 4'h3, 0, 1, 1));
    vecs.push_back(mk(1, 1, 1, 1, 0, 4'h3, 4'h2, 0, 0, 1));
    vecs.push_back(mk(1, 1, 1, 1, 1, 4'h3, 4'h1, 0, 0, 0));
    vecs.push_back(mk(1, 1, 1, 1, 0, 4'h3, 4'h0, 1, 0, 0));
    vecs.push_back(mk(1, 1, 1, 1, 1, 4'h3, 4'h3, 0, 1, 1));
    vecs.push_back(mk(1, 1, 0, 1, 0, 4'h3, 4'h3, 0, 0, 1));
    vecs.push_back(mk(1, 0, 1, 1, 0, 4'h3, 4'h3, 0, 0, 1));
    vecs.push_back(mk(0, 1, 1, 0, 0, 4'h0, 4'h0, 1, 0, 1));
    vecs.push_back(mk(1, 1, 0, 0, 0, 4'h0, 4'h0, 0, 0, 1));
    vecs.push_back(mk(1, 1, 1, 1, 0, 4'h0, 4'h0, 1, 1, 1));
    vecs.push_back(mk(1, 1, 1, 1, 0, 4'h0, 4'h0, 1, 1, 1));
    vecs.push_back(mk(1, 1, 1, 1, 0, 4'h0, 4'h0, 1, 1, 1));
    vecs.push_back(mk(0, 1, 1, 1, 0, 4'h5, 4'h5, 0, 0, 1));
    vecs.push_back(mk(1, 1, 1, 1, 0, 4'h9, 4'h4, 0, 0, 1));

    #1;
    check("reset q4", 8'(q4), 8'h00);
    check("reset tcp4", 8'(tcp4), 8'h00);
    check("reset uf4", 8'(uf4), 8'h00);
    check("reset q8", q8, 8'h00);
    @(negedge cp);
    cr = 1'b0;

    foreach (vecs[i]) begin
      drive(vecs[i].ldbar, vecs[i].ctp, vecs[i].ctt, vecs[i].reload, vecs[i].clruf,
            vecs[i].d, 8'h00);
      check($sformatf("vec%0d q", i), 8'(q4), 8'(vecs[i].q));
      check($sformatf("vec%0d bo", i), 8'(bo4), 8'(vecs[i].bo));
      check($sformatf("vec%0d tcp", i), 8'(tcp4), 8'(vecs[i].tcp));
      check($sformatf("vec%0d uf", i), 8'(uf4), 8'(vecs[i].uf));
    end

    // Async reset mid-cycle with a pending TCP and UF set at Q=5.
    drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 8'h00);
    drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 4'h5, 8'h00);
    check("pre-reset q", 8'(q4), 8'h05);
    check("pre-reset tcp", 8'(tcp4), 8'h01);
    check("pre-reset uf", 8'(uf4), 8'h01);
    #1 cr = 1'b1;
    #1;
    check("async q", 8'(q4), 8'h00);
    check("async tcp", 8'(tcp4), 8'h00);
    check("async uf", 8'(uf4), 8'h00);
    @(negedge cp);
    cr = 1'b0; ctp = 1'b0; ctt = 1'b0; ldbar = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(posedge cp);
      #1;
      check($sformatf("post-reset hold%0d q", k), 8'(q4), 8'h00);
      check($sformatf("post-reset hold%0d tcp", k), 8'(tcp4), 8'h00);
    end

    // Cascade across two slices.
    step8("c-load10", 1'b0, 1'b1, 1'b1, 1'b0, 8'h10, 8'h10, 1'b0, 1'b0, 1'b0);
    step8("c-borrow", 1'b1, 1'b1, 1'b1, 1'b0, 8'h10, 8'h0F, 1'b0, 1'b0, 1'b0);
    step8("c-load00", 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0);
    step8("c-wrap", 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 8'hFF, 1'b0, 1'b1, 1'b1);
    step8("c-count", 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 8'hFE, 1'b0, 1'b0, 1'b1);
    step8("c-freeze", 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 8'hFE, 1'b0, 1'b0, 1'b1);
    step8("c-load0b", 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1);
    step8("c-ctt0", 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
